// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 subset: opcodes, FSM states,
// instruction classes and the ALUSel/ImmSel codes seen by the datapath.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_SHIFT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_ILL = 3'd4
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [1:0] imm_sel;
        logic [3:0] alu_sel;
        logic       bsel;
        logic       wbsel;
    } ctrl_t;

    // Idle field values double as the reset-visible values of the control outputs.
    localparam ctrl_t CTRL_IDLE = '{cls: CLS_ILL, imm_sel: IMM_I, alu_sel: ALU_ADD,
                                    bsel: 1'b0, wbsel: 1'b1};

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational decode of the instruction register into class and
// datapath control fields.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (opcode)
            OPC_R: begin
                ctrl.cls     = CLS_R;
                ctrl.alu_sel = {funct7_5, funct3};
                ctrl.bsel    = 1'b0;
                ctrl.wbsel   = 1'b1;
            end
            OPC_I: begin
                ctrl.cls = CLS_I;
                // Only the shift-right pair uses bit 30 to pick logical vs arithmetic.
                ctrl.alu_sel = (funct3 == F3_SHIFT) ? {funct7_5, funct3} : {1'b0, funct3};
                ctrl.bsel    = 1'b1;
                ctrl.wbsel   = 1'b1;
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    ctrl.cls     = CLS_LW;
                    ctrl.alu_sel = ALU_ADD;
                    ctrl.bsel    = 1'b1;
                    ctrl.wbsel   = 1'b0;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD) begin
                    ctrl.cls     = CLS_SW;
                    ctrl.imm_sel = IMM_S;
                    ctrl.alu_sel = ALU_ADD;
                    ctrl.bsel    = 1'b1;
                    ctrl.wbsel   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, PC, IR,
// retired-instruction counter and a sticky illegal-instruction trap.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instructionCode,
    output logic [1:0]  ImmSel,
    output logic        RegWEn,
    output logic        BSel,
    output logic [3:0]  ALUSel,
    output logic        MemRW,
    output logic        WBSel,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [2:0]  dbg_state
);

    // imem handshake: imem_rdata is taken on the first rising edge in FETCH
    // where imem_valid=1; there is no ready, FETCH itself is the ready window.

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;
    logic        retire;
    logic        active;
    ctrl_t       dec;

    ctrl_decode u_ctrl_decode (
        .opcode  (ir_q[6:0]),
        .funct3  (ir_q[14:12]),
        .funct7_5(ir_q[30]),
        .ctrl    (dec)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            instret_q <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec.cls == CLS_ILL) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = (dec.cls == CLS_LW || dec.cls == CLS_SW) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dec.cls == CLS_SW) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_TRAP: begin
                illegal_d = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
        // Both counters wrap naturally at 2^32.
        if (retire) begin
            pc_d      = pc_q + 32'd4;
            instret_d = instret_q + 32'd1;
        end
    end

    always_comb begin
        active = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                 (state_q == ST_MEM)    || (state_q == ST_WB);
        ImmSel          = active ? dec.imm_sel : CTRL_IDLE.imm_sel;
        ALUSel          = active ? dec.alu_sel : CTRL_IDLE.alu_sel;
        BSel            = active ? dec.bsel    : CTRL_IDLE.bsel;
        WBSel           = active ? dec.wbsel   : CTRL_IDLE.wbsel;
        RegWEn          = (state_q == ST_WB) && (ir_q[11:7] != 5'd0);
        MemRW           = (state_q == ST_MEM) && (dec.cls == CLS_SW);
        imem_addr       = pc_q;
        instructionCode = ir_q;
        illegal         = illegal_q;
        instret         = instret_q;
        dbg_state       = state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expectations are
// queued at issue and compared when the FSM returns to FETCH.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] instructionCode;
    logic [1:0]  ImmSel;
    logic        RegWEn;
    logic        BSel;
    logic [3:0]  ALUSel;
    logic        MemRW;
    logic        WBSel;
    logic        illegal;
    logic [31:0] instret;
    logic [2:0]  dbg_state;

    multicycle_ctrl #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RST(RST),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instructionCode(instructionCode), .ImmSel(ImmSel), .RegWEn(RegWEn),
        .BSel(BSel), .ALUSel(ALUSel), .MemRW(MemRW), .WBSel(WBSel),
        .illegal(illegal), .instret(instret), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  alu;
        logic        bsel;
        logic        wbsel;
        logic        wb_care;
        logic [1:0]  imm;
        logic [2:0]  lat;
        logic [2:0]  wen_cyc;
        logic [2:0]  mem_cyc;
        logic [31:0] pc;
        logic [31:0] instret;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [31:0]  pc_m     = RST_PC;
    logic [31:0]  instret_m = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic accept(input logic [31:0] instr);
        @(negedge CLK);
        imem_rdata = instr;
        imem_valid = 1'b1;
        @(posedge CLK);
        #1;
        imem_valid = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Drive one legal instruction, queue its expectation, monitor, then score.
    task automatic issue(input string name, input logic [31:0] instr, input logic [3:0] alu,
                         input logic bsel, input logic wbsel, input logic wb_care,
                         input logic [1:0] imm, input logic [2:0] lat,
                         input logic [2:0] wen_cyc, input logic [2:0] mem_cyc);
        exp_t       e;
        logic [8:0] f0;
        logic       unstable;
        int         n;
        logic [2:0] wen_seen, mem_seen;
        pc_m      = pc_m + 32'd4;
        instret_m = instret_m + 32'd1;
        e = '{alu: alu, bsel: bsel, wbsel: wbsel, wb_care: wb_care, imm: imm, lat: lat,
              wen_cyc: wen_cyc, mem_cyc: mem_cyc, pc: pc_m, instret: instret_m};
        exp_q.push_back(W'(e));
        accept(instr);
        n = 0; f0 = '0; unstable = 1'b0; wen_seen = 3'd0; mem_seen = 3'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (dbg_state == 3'(ST_FETCH)) break;
            n = c;
            if (c == 1) f0 = {ALUSel, BSel, WBSel, ImmSel, 1'b0};
            else if ({ALUSel, BSel, WBSel, ImmSel, 1'b0} !== f0) unstable = 1'b1;
            if (RegWEn) wen_seen = (wen_seen == 3'd0) ? 3'(c) : 3'd7;
            if (MemRW)  mem_seen = (mem_seen == 3'd0) ? 3'(c) : 3'd7;
        end
        check({name, "_queue"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_t'(exp_q.pop_front());
            check({name, "_alusel"}, 32'(f0[8:5]), 32'(e.alu));
            check({name, "_bsel"}, 32'(f0[4]), 32'(e.bsel));
            if (e.wb_care) check({name, "_wbsel"}, 32'(f0[3]), 32'(e.wbsel));
            check({name, "_immsel"}, 32'(f0[2:1]), 32'(e.imm));
            check({name, "_stable"}, 32'(unstable), 32'd0);
            check({name, "_latency"}, 32'(n), 32'(e.lat));
            check({name, "_regwen_cyc"}, 32'(wen_seen), 32'(e.wen_cyc));
            check({name, "_memrw_cyc"}, 32'(mem_seen), 32'(e.mem_cyc));
            check({name, "_pc"}, imem_addr, e.pc);
            check({name, "_instret"}, instret, e.instret);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_state"}, 32'(dbg_state), 32'(ST_FETCH));
        check({name, "_pc"}, imem_addr, RST_PC);
        check({name, "_ir"}, instructionCode, 32'h0);
        check({name, "_instret"}, instret, 32'h0);
        check({name, "_illegal"}, 32'(illegal), 32'd0);
        check({name, "_strobes"}, 32'({RegWEn, MemRW}), 32'd0);
        check({name, "_fields"}, 32'({BSel, ImmSel, ALUSel, WBSel}), 32'(8'b0_00_0000_1));
    endtask

    initial begin
        logic [31:0] ir;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        b30;

        // reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("por");
        RST = 1'b0;

        // FETCH holds while imem_valid is low
        repeat (5) begin
            @(negedge CLK);
            imem_rdata = $urandom;
            check("hold_state", 32'(dbg_state), 32'(ST_FETCH));
            check("hold_pc", imem_addr, RST_PC);
        end

        issue("add",   32'h002081B3, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00, 3'd3, 3'd3, 3'd0);
        issue("sub",   32'h402081B3, 4'b1000, 1'b0, 1'b1, 1'b1, 2'b00, 3'd3, 3'd3, 3'd0);
        issue("lw",    32'h0000A183, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b00, 3'd4, 3'd4, 3'd0);
        issue("sw",    32'h0030A023, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b01, 3'd3, 3'd0, 3'd3);
        issue("nop",   32'h00000013, 4'b0000, 1'b1, 1'b1, 1'b1, 2'b00, 3'd3, 3'd0, 3'd0);
        issue("srai",  32'h4030D193, 4'b1101, 1'b1, 1'b1, 1'b1, 2'b00, 3'd3, 3'd3, 3'd0);
        issue("addi30", 32'h40008193, 4'b0000, 1'b1, 1'b1, 1'b1, 2'b00, 3'd3, 3'd3, 3'd0);

        // random I-ALU and R-ALU instructions
        for (int k = 0; k < 6; k++) begin
            f3  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 31));
            b30 = 1'($urandom_range(0, 1));
            ir  = $urandom;
            ir[30] = b30; ir[14:12] = f3; ir[11:7] = rd;
            if (k[0]) begin
                ir[6:0] = 7'b0010011;
                issue("rnd_i", ir, (f3 == 3'b101) ? {b30, f3} : {1'b0, f3}, 1'b1, 1'b1, 1'b1,
                      2'b00, 3'd3, (rd != 5'd0) ? 3'd3 : 3'd0, 3'd0);
            end else begin
                ir[6:0] = 7'b0110011;
                issue("rnd_r", ir, {b30, f3}, 1'b0, 1'b1, 1'b1,
                      2'b00, 3'd3, (rd != 5'd0) ? 3'd3 : 3'd0, 3'd0);
            end
        end

        // asynchronous reset in the middle of an LW's EXEC cycle
        accept(32'h0000A183);
        @(negedge CLK);
        @(negedge CLK);
        check("lw_mid_state", 32'(dbg_state), 32'(ST_EXEC));
        check("lw_mid_bsel", 32'(BSel), 32'd1);
        #2 RST = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        pc_m = RST_PC;
        instret_m = 32'h0;
        check("post_rst_fetch_addr", imem_addr, RST_PC);
        issue("add_after_rst", 32'h002081B3, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00, 3'd3, 3'd3, 3'd0);

        // illegal opcode traps; imem activity is then ignored
        accept(32'hFFFFFFFF);
        @(negedge CLK);
        @(negedge CLK);
        check("trap_state", 32'(dbg_state), 32'(ST_TRAP));
        check("trap_illegal", 32'(illegal), 32'd1);
        imem_valid = 1'b1;
        repeat (4) begin
            imem_rdata = $urandom;
            @(negedge CLK);
            check("trap_hold", 32'(dbg_state), 32'(ST_TRAP));
            check("trap_pc", imem_addr, pc_m);
            check("trap_instret", instret, instret_m);
            check("trap_strobes", 32'({RegWEn, MemRW, illegal}), 32'd1);
        end
        imem_valid = 1'b0;
        #2 RST = 1'b1;
        #1 check_reset_outputs("trap_rst");
        @(negedge CLK);
        RST = 1'b0;
        pc_m = RST_PC;
        instret_m = 32'h0;
        issue("sw_after_trap", 32'h0030A023, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b01, 3'd3, 3'd0, 3'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
